// File: rtl/regfile_div_arbiter.sv
// rtl/regfile_div_arbiter.sv - arbitrates the single-port divider-result register file
// between the divider (writer) and the back-substitution stage (reader).
module regfile_div_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int SIZE   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_rsp_data,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_D,
  input  logic [DATA_W-1:0] rf_Q,
  output logic [ADDR_W:0]   wr_count,
  output logic              all_written,
  output logic              addr_err
);

  localparam int NENT = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] SIZE_L = (ADDR_W + 1)'(SIZE);

  logic [NENT-1:0] sb;
  logic            last_rd;
  logic            rsp_oor;
  logic            wr_oor, rd_oor;
  logic            we, re;
  logic            gnt_wr, gnt_rd;

  assign wr_oor = {1'b0, wr_addr} >= SIZE_L;
  assign rd_oor = {1'b0, rd_addr} >= SIZE_L;

  // Out-of-range reads are eligible so they can be answered (with zero) and flagged.
  assign we = wr_valid & ~clr;
  assign re = rd_valid & ~clr & (rd_oor | sb[rd_addr]);

  assign gnt_wr = rst & we & (~re | last_rd);
  assign gnt_rd = rst & re & ~gnt_wr;

  assign wr_ready    = gnt_wr;
  assign rd_ready    = gnt_rd;
  assign all_written = (wr_count == SIZE_L);
  assign rd_rsp_data = (rd_rsp_valid && !rsp_oor) ? rf_Q : '0;

  always_comb begin
    rf_wr_en = 1'b0;
    rf_rd_en = 1'b0;
    rf_addr  = '0;
    rf_D     = '0;
    if (gnt_wr && !wr_oor) begin
      rf_wr_en = 1'b1;
      rf_addr  = wr_addr;
      rf_D     = wr_data;
    end else if (gnt_rd && !rd_oor) begin
      rf_rd_en = 1'b1;
      rf_addr  = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb           <= '0;
      wr_count     <= '0;
      addr_err     <= 1'b0;
      rd_rsp_valid <= 1'b0;
      rsp_oor      <= 1'b0;
      last_rd      <= 1'b1;
    end else begin
      addr_err     <= (gnt_wr & wr_oor) | (gnt_rd & rd_oor);
      rd_rsp_valid <= gnt_rd;
      rsp_oor      <= rd_oor;
      if (gnt_wr)
        last_rd <= 1'b0;
      else if (gnt_rd)
        last_rd <= 1'b1;
      // Count distinct entries only; rewrites leave the count alone.
      if (clr) begin
        sb       <= '0;
        wr_count <= '0;
      end else if (gnt_wr && !wr_oor) begin
        sb[wr_addr] <= 1'b1;
        if (!sb[wr_addr])
          wr_count <= wr_count + (ADDR_W + 1)'(1);
      end
    end
  end

endmodule
